// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with 2-entry issue buffer
module fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic [7:0]  pc_o,
    input  logic [15:0] instr_i,
    output logic [15:0] instr_o,
    output logic [7:0]  instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [7:0]  redirect_pc_i,
    output logic        busy_o,
    output logic        halt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [1:0]  count_q, count_d;

    // Buffer slot 0 is always the head; slot 1 is the second-oldest entry.
    logic [7:0]  e0_pc_q, e0_pc_d;
    logic [15:0] e0_instr_q, e0_instr_d;
    logic [7:0]  e1_pc_q, e1_pc_d;
    logic [15:0] e1_instr_q, e1_instr_d;

    logic        pop;
    logic        fetch_en;
    logic        halt_word;
    logic        push;
    logic        flush;

    assign instr_valid_o = (count_q != 2'd0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign halt_word     = (instr_i[15:12] == 4'hF);

    // A fetch needs a free slot now, or one freed by a same-cycle pop;
    // a redirect always wins over fetching.
    assign fetch_en = (state_q == S_FETCH) && !redirect_i &&
                      ((count_q < 2'd2) || pop);
    assign push     = fetch_en && !halt_word;

    assign pc_o       = pc_q;
    assign instr_o    = e0_instr_q;
    assign instr_pc_o = e0_pc_q;
    assign busy_o     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign halt_o     = (state_q == S_HALT);

    // Next-state, next-pc and buffer-clear decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                // start beats a simultaneous redirect; redirect alone is ignored here
                if (start_i) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                    flush   = 1'b1;
                end
            end
            S_FETCH: begin
                if (redirect_i) begin
                    state_d = S_FETCH;
                    pc_d    = redirect_pc_i;
                    flush   = 1'b1;
                end else if (fetch_en) begin
                    if (halt_word) begin
                        // HALT word is consumed here: nothing buffered, pc stays on it
                        state_d = S_DRAIN;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_i) begin
                    state_d = S_FETCH;
                    pc_d    = redirect_pc_i;
                    flush   = 1'b1;
                end else if (count_q == 2'd0) begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Buffer update: pop shifts slot 1 to the head, push lands at the tail.
    always_comb begin
        count_d    = count_q;
        e0_pc_d    = e0_pc_q;
        e0_instr_d = e0_instr_q;
        e1_pc_d    = e1_pc_q;
        e1_instr_d = e1_instr_q;
        unique case ({push, pop})
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_pc_d    = pc_q;
                    e0_instr_d = instr_i;
                end else begin
                    e0_pc_d    = e1_pc_q;
                    e0_instr_d = e1_instr_q;
                    e1_pc_d    = pc_q;
                    e1_instr_d = instr_i;
                end
            end
            2'b01: begin
                e0_pc_d    = e1_pc_q;
                e0_instr_d = e1_instr_q;
                count_d    = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_pc_d    = pc_q;
                    e0_instr_d = instr_i;
                end else begin
                    e1_pc_d    = pc_q;
                    e1_instr_d = instr_i;
                end
                count_d = count_q + 2'd1;
            end
            default: begin
                count_d = count_q;
            end
        endcase
        // Stale slot contents are left in place; count==0 marks them invalid.
        if (flush) begin
            count_d = 2'd0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter, occupancy and buffer slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            e0_pc_q    <= 8'h00;
            e0_instr_q <= 16'h0000;
            e1_pc_q    <= 8'h00;
            e1_instr_q <= 16'h0000;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            e0_pc_q    <= e0_pc_d;
            e0_instr_q <= e0_instr_d;
            e1_pc_q    <= e1_pc_d;
            e1_instr_q <= e1_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  pc_o;
    logic [15:0] instr_i;
    logic [15:0] instr_o;
    logic [7:0]  instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [7:0]  redirect_pc_i;
    logic        busy_o;
    logic        halt_o;

    logic [15:0] rom [256];

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .busy_o        (busy_o),
        .halt_o        (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_i = rom[pc_o];

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        ready;
        logic        redirect;
        logic [7:0]  rpc;
        logic        valid;
        logic [7:0]  ipc;
        logic [15:0] instr;
        logic [7:0]  pc;
        logic        busy;
        logic        halt;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rdy,
                                input logic rd, input logic [7:0] rpc,
                                input logic v, input logic [7:0] ipc,
                                input logic [15:0] ins, input logic [7:0] pc,
                                input logic b, input logic h, input logic cd);
        vec_t t;
        t.rst_n = r; t.start = s; t.ready = rdy; t.redirect = rd; t.rpc = rpc;
        t.valid = v; t.ipc = ipc; t.instr = ins; t.pc = pc;
        t.busy = b; t.halt = h; t.chk_data = cd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic rdy, input logic rd, input logic [7:0] rpc);
        @(negedge clk);
        start_i       = s;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start_i = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
        rst_n = 1'b0; start_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 8'h00;

        //              rst st rdy rd rpc    | v  ipc    instr     pc     b  h  cd
        vecs.push_back(mk(0, 0, 0, 0, 8'h00,  0, 8'h00, 16'h0000, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00,  0, 8'h00, 16'h0000, 8'h00, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h00, 16'h1000, 8'h01, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h01, 16'h1001, 8'h02, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h02, 16'h1002, 8'h03, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h03, 16'h1003, 8'h04, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00,  0, 8'h00, 16'h0000, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  0, 8'h00, 16'h0000, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00,  0, 8'h00, 16'h0000, 8'h00, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00,  1, 8'h00, 16'h1000, 8'h01, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00,  1, 8'h00, 16'h1000, 8'h02, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00,  1, 8'h00, 16'h1000, 8'h02, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00,  1, 8'h00, 16'h1000, 8'h02, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h01, 16'h1001, 8'h03, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h02, 16'h1002, 8'h04, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 8'h40,  0, 8'h00, 16'h0000, 8'h40, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h40, 16'h1040, 8'h41, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00,  1, 8'h40, 16'h1040, 8'h42, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8'h80,  0, 8'h00, 16'h0000, 8'h80, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h80, 16'h1080, 8'h81, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h81, 16'h1081, 8'h82, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00,  0, 8'h00, 16'h0000, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8'h33,  0, 8'h00, 16'h0000, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h33,  0, 8'h00, 16'h0000, 8'h00, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00,  1, 8'h00, 16'h1000, 8'h01, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00,  1, 8'h01, 16'h1001, 8'h02, 1, 0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            start_i       = vecs[i].start;
            instr_ready_i = vecs[i].ready;
            redirect_i    = vecs[i].redirect;
            redirect_pc_i = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid", i), 32'(instr_valid_o), 32'(vecs[i].valid));
            chk($sformatf("row%0d pc", i),    32'(pc_o),          32'(vecs[i].pc));
            chk($sformatf("row%0d busy", i),  32'(busy_o),        32'(vecs[i].busy));
            chk($sformatf("row%0d halt", i),  32'(halt_o),        32'(vecs[i].halt));
            if (vecs[i].chk_data) begin
                chk($sformatf("row%0d instr_pc", i), 32'(instr_pc_o), 32'(vecs[i].ipc));
                chk($sformatf("row%0d instr", i),    32'(instr_o),    32'(vecs[i].instr));
            end
        end

        // HALT word at 0x05: drain, halt, ignore redirect in HALT, restart
        do_reset();
        rom[5] = 16'hF000;
        step(1, 1, 0, 8'h00);
        chk("halt start busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00);
            chk($sformatf("halt issue%0d valid", i), 32'(instr_valid_o), 32'd1);
            chk($sformatf("halt issue%0d pc", i), 32'(instr_pc_o), 32'(i));
        end
        chk("halt pc before", 32'(pc_o), 32'h05);
        step(0, 1, 0, 8'h00);
        chk("drain valid", 32'(instr_valid_o), 32'd0);
        chk("drain busy", 32'(busy_o), 32'd1);
        chk("drain halt", 32'(halt_o), 32'd0);
        chk("drain pc", 32'(pc_o), 32'h05);
        step(0, 1, 0, 8'h00);
        chk("halt halt_o", 32'(halt_o), 32'd1);
        chk("halt busy", 32'(busy_o), 32'd0);
        chk("halt pc", 32'(pc_o), 32'h05);
        step(0, 1, 1, 8'h77);
        chk("halt redirect ignored halt", 32'(halt_o), 32'd1);
        chk("halt redirect ignored pc", 32'(pc_o), 32'h05);
        step(1, 1, 0, 8'h00);
        chk("restart busy", 32'(busy_o), 32'd1);
        chk("restart halt", 32'(halt_o), 32'd0);
        chk("restart pc", 32'(pc_o), 32'h00);
        step(0, 1, 0, 8'h00);
        chk("restart issue pc", 32'(instr_pc_o), 32'h00);
        chk("restart issue instr", 32'(instr_o), 32'h1000);
        rom[5] = 16'h1005;

        // pc wrap from 0xFF to 0x00
        do_reset();
        step(1, 1, 0, 8'h00);
        step(0, 1, 1, 8'hFF);
        chk("wrap redirect pc", 32'(pc_o), 32'hFF);
        chk("wrap redirect valid", 32'(instr_valid_o), 32'd0);
        step(0, 1, 0, 8'h00);
        chk("wrap issue ff", 32'(instr_pc_o), 32'hFF);
        chk("wrap instr ff", 32'(instr_o), 32'h10FF);
        chk("wrap pc 00", 32'(pc_o), 32'h00);
        step(0, 1, 0, 8'h00);
        chk("wrap issue 00", 32'(instr_pc_o), 32'h00);
        chk("wrap pc 01", 32'(pc_o), 32'h01);

        // redirect while draining returns to FETCH
        do_reset();
        rom[2] = 16'hF000;
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        chk("dr drain valid", 32'(instr_valid_o), 32'd1);
        chk("dr drain ipc", 32'(instr_pc_o), 32'h01);
        chk("dr drain pc", 32'(pc_o), 32'h02);
        chk("dr drain busy", 32'(busy_o), 32'd1);
        step(0, 0, 1, 8'h10);
        chk("dr redirect valid", 32'(instr_valid_o), 32'd0);
        chk("dr redirect pc", 32'(pc_o), 32'h10);
        chk("dr redirect halt", 32'(halt_o), 32'd0);
        step(0, 1, 0, 8'h00);
        chk("dr refetch ipc", 32'(instr_pc_o), 32'h10);
        chk("dr refetch instr", 32'(instr_o), 32'h1010);
        chk("dr refetch pc", 32'(pc_o), 32'h11);
        rom[2] = 16'h1002;

        // asynchronous reset mid-stream with a full buffer
        do_reset();
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("ar full valid", 32'(instr_valid_o), 32'd1);
        chk("ar full pc", 32'(pc_o), 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar async valid", 32'(instr_valid_o), 32'd0);
        chk("ar async pc", 32'(pc_o), 32'h00);
        chk("ar async busy", 32'(busy_o), 32'd0);
        chk("ar async instr", 32'(instr_o), 32'h0000);
        chk("ar async ipc", 32'(instr_pc_o), 32'h00);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            chk($sformatf("ar idle%0d valid", i), 32'(instr_valid_o), 32'd0);
            chk($sformatf("ar idle%0d busy", i), 32'(busy_o), 32'd0);
        end
        step(1, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        chk("ar restart valid", 32'(instr_valid_o), 32'd1);
        chk("ar restart ipc", 32'(instr_pc_o), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
